// File: rtl/ring_osc_pkg.sv
// Shared types and defaults for the ring oscillator measurement sequencer.
package ring_osc_pkg;

  localparam int TAP_W_DEF = 3;
  localparam int CNT_W_DEF = 15;
  localparam int NUM_TAPS  = 2 ** TAP_W_DEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    GATE    = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4,
    EMIT    = 3'd5
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ring_osc_meas_timer.sv
// Loadable down-counter shared by the CLEAR, GATE and SETTLE phases.
// Loading N-1 keeps a phase alive for N cycles; expired_o marks the last one.
module meas_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Measurement sequencer: clear counter, gate the selected ring tap for a fixed
// window, let the ripple counter settle, capture and emit the count.
module ring_osc_meas_ctrl
  import ring_osc_pkg::*;
#(
  parameter int GATE_CYCLES   = 1024,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int TAP_W         = TAP_W_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sweep_i,
  input  logic [TAP_W-1:0] tap_sel_i,
  input  logic             abort_i,
  output logic             ring_en_o,
  output logic [TAP_W-1:0] ring_tap_o,
  output logic             cnt_clr_o,
  input  logic [CNT_W-1:0] cnt_val_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [TAP_W-1:0] res_tap_o,
  output logic [CNT_W-1:0] res_count_o,
  output logic             res_sat_o,
  output logic             busy_o,
  output logic             done_o,
  output state_t           state_o
);

  localparam int TMR_MAX = max3(GATE_CYCLES, CLR_CYCLES, SETTLE_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] CLR_LOAD    = TMR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  // Result port handshake: a result is transferred on a clk edge where
  // res_valid_o & res_ready_i; res_tap/res_count/res_sat stay stable while
  // res_valid_o is high and not yet accepted. res_ready_i is ignored otherwise.

  state_t             state_q,    state_d;
  logic               sweep_q,    sweep_d;
  logic [TAP_W-1:0]   tap_q,      tap_d;
  logic [TAP_W-1:0]   ring_tap_q, ring_tap_d;
  logic               ring_en_q;
  logic               cnt_clr_q;
  logic               res_valid_q;
  logic               busy_q;
  logic               done_q,     done_d;
  logic [TAP_W-1:0]   res_tap_q;
  logic [CNT_W-1:0]   res_count_q;
  logic               res_sat_q;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_expired;
  logic               capture;

  meas_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    tap_d      = tap_q;
    ring_tap_d = ring_tap_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    capture    = 1'b0;

    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sweep_d    = sweep_i;
            tap_d      = sweep_i ? '0 : tap_sel_i;
            ring_tap_d = tap_d;
            tmr_load   = 1'b1;
            tmr_value  = CLR_LOAD;
            state_d    = CLEAR;
          end
        end
        CLEAR: begin
          if (tmr_expired) begin
            tmr_load  = 1'b1;
            tmr_value = GATE_LOAD;
            state_d   = GATE;
          end
        end
        GATE: begin
          if (tmr_expired) begin
            tmr_load  = 1'b1;
            tmr_value = SETTLE_LOAD;
            state_d   = SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_expired) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          capture = 1'b1;
          state_d = EMIT;
        end
        EMIT: begin
          if (res_ready_i) begin
            // The last tap ends the sweep, so the tap register never wraps.
            if (sweep_q && !(&tap_q)) begin
              tap_d      = tap_q + TAP_W'(1);
              ring_tap_d = tap_d;
              tmr_load   = 1'b1;
              tmr_value  = CLR_LOAD;
              state_d    = CLEAR;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sweep_q    <= 1'b0;
      tap_q      <= '0;
      ring_tap_q <= '0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      tap_q      <= tap_d;
      ring_tap_q <= ring_tap_d;
    end
  end

  // Control outputs are decoded from the next state so they are registered
  // yet line up with the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ring_en_q   <= 1'b0;
      cnt_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ring_en_q   <= (state_d == GATE);
      cnt_clr_q   <= (state_d == CLEAR);
      res_valid_q <= (state_d == EMIT);
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_tap_q   <= '0;
      res_count_q <= '0;
      res_sat_q   <= 1'b0;
    end else if (capture) begin
      res_tap_q   <= tap_q;
      res_count_q <= cnt_val_i;
      res_sat_q   <= &cnt_val_i;
    end
  end

  assign ring_en_o   = ring_en_q;
  assign ring_tap_o  = ring_tap_q;
  assign cnt_clr_o   = cnt_clr_q;
  assign res_valid_o = res_valid_q;
  assign res_tap_o   = res_tap_q;
  assign res_count_o = res_count_q;
  assign res_sat_o   = res_sat_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Bench for ring_osc_meas_ctrl with a behavioural ring+counter and a
// schedule-based reference model checked every cycle.
module tb_ring_osc_meas_ctrl;
  import ring_osc_pkg::*;

  localparam int GATE   = 16;
  localparam int CLR    = 2;
  localparam int SETTLE = 4;
  localparam int TAP_W  = 3;
  localparam int CNT_W  = 15;
  localparam int W      = TAP_W + CNT_W + 1;
  // Offsets (in cycles after the start/handshake edge) of each phase.
  localparam int OFF_GATE = CLR;
  localparam int OFF_SETL = CLR + GATE;
  localparam int OFF_EMIT = CLR + GATE + SETTLE + 1;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, sweep = 1'b0, abort = 1'b0, res_ready = 1'b0;
  logic [TAP_W-1:0] tap_sel = '0;
  logic [CNT_W-1:0] cnt_val;
  logic ring_en, cnt_clr, res_valid, res_sat, busy, done;
  logic [TAP_W-1:0] ring_tap, res_tap;
  logic [CNT_W-1:0] res_count;
  state_t state;

  always #5 clk = ~clk;

  ring_osc_meas_ctrl #(
    .GATE_CYCLES (GATE), .CLR_CYCLES (CLR), .SETTLE_CYCLES (SETTLE),
    .TAP_W (TAP_W), .CNT_W (CNT_W)
  ) dut (
    .clk_i (clk), .rst_i (rst), .start_i (start), .sweep_i (sweep),
    .tap_sel_i (tap_sel), .abort_i (abort), .ring_en_o (ring_en),
    .ring_tap_o (ring_tap), .cnt_clr_o (cnt_clr), .cnt_val_i (cnt_val),
    .res_valid_o (res_valid), .res_ready_i (res_ready), .res_tap_o (res_tap),
    .res_count_o (res_count), .res_sat_o (res_sat), .busy_o (busy),
    .done_o (done), .state_o (state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit cmp_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ring oscillator + ripple counter model ----------------
  int unsigned inc = 3;
  bit sat_mode = 0;
  logic [CNT_W-1:0] ring_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)          ring_cnt <= '0;
    else if (cnt_clr) ring_cnt <= '0;
    else if (ring_en) ring_cnt <= ring_cnt + CNT_W'(inc);
  end
  assign cnt_val = sat_mode ? {CNT_W{1'b1}} : ring_cnt;

  // ---------------- reference model ----------------
  bit m_active = 0, m_sweep = 0;
  int m_seg = 0, m_done_cyc = -1;
  logic [TAP_W-1:0] m_tap = '0, m_ring_tap = '0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] exp_result(input logic [TAP_W-1:0] t);
    logic [CNT_W-1:0] c;
    c = sat_mode ? {CNT_W{1'b1}} : CNT_W'(inc * GATE);
    return {t, c, &c};
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit was_emit;
    if (rst) begin
      m_active = 0; m_tap = '0; m_ring_tap = '0; m_done_cyc = -1;
      exp_q.delete();
    end else begin
      was_emit = m_active && ((cyc - m_seg) >= OFF_EMIT);
      cyc++;
      if (abort) begin
        m_active = 0;
        exp_q.delete();
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_sweep = sweep;
          m_tap = sweep ? '0 : tap_sel;
          m_ring_tap = m_tap; m_seg = cyc;
          exp_q.push_back(exp_result(m_tap));
        end
      end else if (was_emit && res_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_sweep && m_tap != {TAP_W{1'b1}}) begin
          m_tap = m_tap + 1'b1; m_ring_tap = m_tap; m_seg = cyc;
          exp_q.push_back(exp_result(m_tap));
        end else begin
          m_active = 0; m_done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- per-cycle compare + monitors ----------------
  int done_cnt = 0;
  logic [TAP_W-1:0] obs_tap[$];

  always @(negedge clk) begin : compare
    int off;
    logic e_valid;
    logic [TAP_W-1:0] e_tap;
    logic [CNT_W-1:0] e_cnt;
    logic e_sat;
    if (!rst) begin
      if (done) done_cnt++;
      if (res_valid && res_ready) obs_tap.push_back(res_tap);
      if (ring_en && cnt_clr) chk("en_clr_overlap", 1, 0);
    end
    if (!rst && cmp_en) begin
      off = cyc - m_seg;
      e_valid = m_active && off >= OFF_EMIT;
      chk("busy", busy, m_active);
      chk("cnt_clr", cnt_clr, m_active && off < OFF_GATE);
      chk("ring_en", ring_en, m_active && off >= OFF_GATE && off < OFF_SETL);
      chk("res_valid", res_valid, e_valid);
      chk("ring_tap", ring_tap, m_ring_tap);
      chk("done", done, m_done_cyc == cyc);
      if (e_valid) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_empty", 0, 1);
        end else begin
          {e_tap, e_cnt, e_sat} = exp_q[0];
          chk("res_tap", res_tap, e_tap);
          chk("res_count", res_count, e_cnt);
          chk("res_sat", res_sat, e_sat);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic pulse_start(input logic sw, input logic [TAP_W-1:0] t);
    sweep = sw; tap_sel = t; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // sel: 0=res_valid, 1=busy, 2=ring_en
  task automatic wait_sig(input int sel, input logic lvl, input int budget);
    int k;
    logic v;
    for (k = 0; k < budget; k++) begin
      case (sel)
        0:       v = res_valid;
        1:       v = busy;
        default: v = ring_en;
      endcase
      if (v === lvl) break;
      tick();
    end
    chk($sformatf("wait_sig%0d_level%0b", sel, lvl), k < budget, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int lat, en_cycles, d0;
    logic hold_ok;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_ring_en", ring_en, 0);   chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_res_valid", res_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);         chk("rst_ring_tap", ring_tap, 0);
    chk("rst_res_count", res_count, 0); chk("rst_state", state, IDLE);
    tick();
    cmp_en = 1;

    // Single run, tap 5, +3 per gated cycle.
    inc = 3; res_ready = 1'b1; d0 = done_cnt;
    sweep = 1'b0; tap_sel = 3'd5; start = 1'b1;
    lat = 0; en_cycles = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      start = 1'b0;
      if (k == 1) chk("single_ring_tap", ring_tap, 5);
      if (ring_en) en_cycles++;
      if (res_valid && lat == 0) begin
        lat = k;
        chk("single_count", res_count, 48);
        chk("single_tap", res_tap, 5);
        chk("single_sat", res_sat, 0);
      end
      if (lat != 0 && !busy) break;
    end
    tick();
    chk("single_latency", lat, 24);
    chk("single_gate_len", en_cycles, 16);
    chk("single_done_cnt", done_cnt - d0, 1);

    // Full sweep.
    obs_tap.delete(); d0 = done_cnt; inc = 5;
    pulse_start(1'b1, 3'd6);
    wait_sig(1, 1'b0, 2000);
    tick();
    chk("sweep_results", obs_tap.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < obs_tap.size()) chk($sformatf("sweep_tap%0d", i), obs_tap[i], i);
    chk("sweep_done_cnt", done_cnt - d0, 1);

    // Backpressure in a sweep: hold the first result for 50 cycles.
    inc = 100; res_ready = 1'b0;
    pulse_start(1'b1, 3'd0);
    wait_sig(0, 1'b1, 100);
    hold_ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (!(res_valid && !ring_en && !cnt_clr && res_count == 15'd1600 && res_tap == 3'd0))
        hold_ok = 1'b0;
      tick();
    end
    chk("bp_hold_stable", hold_ok, 1);
    res_ready = 1'b1;
    wait_sig(1, 1'b0, 2000);
    tick();

    // Abort mid-GATE in a sweep, then a normal sweep from tap 0.
    d0 = done_cnt; inc = 9;
    pulse_start(1'b1, 3'd0);
    repeat (2 * (OFF_EMIT + 2)) tick();
    wait_sig(2, 1'b1, 100);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ring_en", ring_en, 0); chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0); chk("abort_cnt_clr", cnt_clr, 0);
    repeat (3) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_beats_start", busy, 0);
    obs_tap.delete(); d0 = done_cnt;
    pulse_start(1'b1, 3'd4);
    wait_sig(1, 1'b0, 2000);
    tick();
    chk("post_abort_results", obs_tap.size(), 8);
    if (obs_tap.size() > 0) chk("post_abort_first_tap", obs_tap[0], 0);
    chk("post_abort_done", done_cnt - d0, 1);

    // Start during SETTLE is ignored.
    obs_tap.delete(); inc = 7;
    pulse_start(1'b0, 3'd6);
    wait_sig(2, 1'b1, 100);
    wait_sig(2, 1'b0, 100);
    tick();
    pulse_start(1'b1, 3'd1);
    wait_sig(1, 1'b0, 500);
    tick();
    chk("settle_start_results", obs_tap.size(), 1);
    if (obs_tap.size() > 0) chk("settle_start_tap", obs_tap[0], 6);

    // Saturated counter.
    sat_mode = 1; res_ready = 1'b0;
    pulse_start(1'b0, 3'd3);
    wait_sig(0, 1'b1, 100);
    chk("sat_flag", res_sat, 1);
    chk("sat_count", res_count, 15'h7FFF);
    res_ready = 1'b1;
    wait_sig(1, 1'b0, 100);
    tick();
    sat_mode = 0;

    // Async reset mid-GATE, between clk edges.
    inc = 2;
    pulse_start(1'b1, 3'd0);
    wait_sig(2, 1'b1, 100);
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_ring_en", ring_en, 0); chk("arst_cnt_clr", cnt_clr, 0);
    chk("arst_res_valid", res_valid, 0); chk("arst_busy", busy, 0);
    chk("arst_done", done, 0); chk("arst_ring_tap", ring_tap, 0);
    chk("arst_res_count", res_count, 0); chk("arst_res_sat", res_sat, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_state_idle", state, IDLE);
    repeat (3) tick();
    chk("arst_stays_idle", busy, 0);

    // Randomized runs.
    for (int r = 0; r < 15; r++) begin
      inc = $urandom_range(0, 2047);
      pulse_start(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      for (int c = 0; c < 3000; c++) begin
        res_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 29) == 0) begin
          start = 1'b1; sweep = ($urandom_range(0, 3) == 0);
          tap_sel = 3'($urandom_range(0, 7));
        end
        if ($urandom_range(0, 399) == 0) abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        if (!busy) break;
      end
      chk($sformatf("rand_run%0d_idle", r), busy, 0);
      tick();
    end

    res_ready = 1'b1;
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
